// File: rtl/seq_match_lock_if.sv
// Symbol-entry bus between the keypad/decoder source and the combination-lock stage.
interface seq_match_lock_if;
    logic       sym_valid;
    logic [1:0] sym;
    logic       clear;
    logic       unlocked;
    logic       alarm;
    logic       match;
    logic [2:0] idx;
    logic [1:0] fail_cnt;

    modport master (
        output sym_valid, sym, clear,
        input  unlocked, alarm, match, idx, fail_cnt
    );

    modport slave (
        input  sym_valid, sym, clear,
        output unlocked, alarm, match, idx, fail_cnt
    );
endinterface

// File: rtl/seq_match_lock.sv
// Sequential combination lock: checks 2-bit symbols in order against CODE,
// opens on a full match, and locks out for a while after MAX_FAIL failed attempts.
module seq_match_lock #(
    parameter int          LEN         = 4,
    parameter logic [15:0] CODE        = 16'b10_00_01_11,
    parameter int          MAX_FAIL    = 3,
    parameter int          OPEN_CYCLES = 8,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    seq_match_lock_if.slave    bus
);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [2:0] LAST_IDX = 3'(LEN - 1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t        r_state;
    logic [2:0]    r_idx;
    logic [1:0]    r_fail_cnt;
    logic          r_unlocked;
    logic          r_alarm;
    logic          r_match;
    logic [TW-1:0] r_timer;

    logic [1:0]    w_code_sym;
    logic          w_eq;
    logic [2:0]    w_fail_nxt;

    assign w_code_sym = CODE[{r_idx, 1'b0} +: 2];
    assign w_eq       = (bus.sym == w_code_sym);
    assign w_fail_nxt = {1'b0, r_fail_cnt} + 3'd1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_ENTRY;
            r_idx      <= 3'd0;
            r_fail_cnt <= 2'd0;
            r_unlocked <= 1'b0;
            r_alarm    <= 1'b0;
            r_match    <= 1'b0;
            r_timer    <= '0;
        end else begin
            r_match <= 1'b0;
            case (r_state)
                ST_ENTRY: begin
                    // clear wins over a simultaneous symbol and is not a failure
                    if (bus.clear) begin
                        r_idx <= 3'd0;
                    end else if (bus.sym_valid) begin
                        if (w_eq) begin
                            if (r_idx == LAST_IDX) begin
                                r_state    <= ST_OPEN;
                                r_unlocked <= 1'b1;
                                r_idx      <= 3'd0;
                                r_fail_cnt <= 2'd0;
                                r_timer    <= TW'(OPEN_CYCLES - 1);
                            end else begin
                                r_idx   <= r_idx + 3'd1;
                                r_match <= 1'b1;
                            end
                        end else begin
                            r_idx <= 3'd0;
                            if (int'(w_fail_nxt) < MAX_FAIL) begin
                                r_fail_cnt <= w_fail_nxt[1:0];
                            end else begin
                                r_state    <= ST_LOCKOUT;
                                r_alarm    <= 1'b1;
                                r_fail_cnt <= 2'd0;
                                r_timer    <= TW'(LOCK_CYCLES - 1);
                            end
                        end
                    end
                end
                ST_OPEN: begin
                    if (r_timer == '0 || bus.clear) begin
                        r_state    <= ST_ENTRY;
                        r_unlocked <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state <= ST_ENTRY;
                        r_alarm <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_ENTRY;
                    r_idx      <= 3'd0;
                    r_unlocked <= 1'b0;
                    r_alarm    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.unlocked = r_unlocked;
    assign bus.alarm    = r_alarm;
    assign bus.match    = r_match;
    assign bus.idx      = r_idx;
    assign bus.fail_cnt = r_fail_cnt;
endmodule

// File: tb/tb_seq_match_lock.sv
// Directed bench for seq_match_lock with default parameters (code 3,1,0,2).
module tb_seq_match_lock;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_match_lock_if u_if ();

    seq_match_lock u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs; returns at the following negedge, after the sampling edge.
    task automatic cyc(input logic v, input logic [1:0] s, input logic c);
        u_if.sym_valid = v;
        u_if.sym       = s;
        u_if.clear     = c;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(1'b0, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 2'd0, 1'b0);
            checks++;
            if ({u_if.unlocked, u_if.alarm, u_if.match, u_if.idx, u_if.fail_cnt} !== 8'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got u=%b a=%b m=%b idx=%0d fc=%0d want all 0",
                         i, u_if.unlocked, u_if.alarm, u_if.match, u_if.idx, u_if.fail_cnt);
            end
        end
    endtask

    task automatic test_open;
        logic [1:0] syms [4];
        logic [2:0] exp_idx [4];
        logic       exp_m [4];
        syms    = '{2'd3, 2'd1, 2'd0, 2'd2};
        exp_idx = '{3'd1, 3'd2, 3'd3, 3'd0};
        exp_m   = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, syms[i], 1'b0);
            checks++;
            if (u_if.idx !== exp_idx[i] || u_if.match !== exp_m[i] || u_if.fail_cnt !== 2'd0) begin
                errors++;
                $display("FAIL open_seq step=%0d got idx=%0d m=%b fc=%0d want idx=%0d m=%b fc=0",
                         i, u_if.idx, u_if.match, u_if.fail_cnt, exp_idx[i], exp_m[i]);
            end
        end
        checks++;
        if (u_if.unlocked !== 1'b1) begin
            errors++;
            $display("FAIL open_rise got unlocked=%b want 1", u_if.unlocked);
        end
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 2'd0, 1'b0);
            checks++;
            if (u_if.unlocked !== 1'b1) begin
                errors++;
                $display("FAIL open_hold cyc=%0d got unlocked=%b want 1", i + 2, u_if.unlocked);
            end
        end
        cyc(1'b0, 2'd0, 1'b0);
        checks++;
        if (u_if.unlocked !== 1'b0) begin
            errors++;
            $display("FAIL open_fall got unlocked=%b want 0 after 8 cycles", u_if.unlocked);
        end
    endtask

    task automatic test_wrong_then_right;
        cyc(1'b1, 2'd3, 1'b0);
        cyc(1'b1, 2'd1, 1'b0);
        checks++;
        if (u_if.idx !== 3'd2) begin
            errors++;
            $display("FAIL wrong_pre got idx=%0d want 2", u_if.idx);
        end
        cyc(1'b1, 2'd2, 1'b0);
        checks++;
        if (u_if.idx !== 3'd0 || u_if.fail_cnt !== 2'd1 || u_if.match !== 1'b0) begin
            errors++;
            $display("FAIL wrong_third got idx=%0d fc=%0d m=%b want idx=0 fc=1 m=0",
                     u_if.idx, u_if.fail_cnt, u_if.match);
        end
        cyc(1'b1, 2'd3, 1'b0);
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0);
        checks++;
        if (u_if.unlocked !== 1'b1 || u_if.fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL retry_open got u=%b fc=%0d want u=1 fc=0", u_if.unlocked, u_if.fail_cnt);
        end
        // clear in OPEN closes at once; the symbol on that exit edge is dropped
        cyc(1'b1, 2'd3, 1'b1);
        checks++;
        if (u_if.unlocked !== 1'b0 || u_if.idx !== 3'd0 || u_if.match !== 1'b0) begin
            errors++;
            $display("FAIL open_clear got u=%b idx=%0d m=%b want u=0 idx=0 m=0",
                     u_if.unlocked, u_if.idx, u_if.match);
        end
        cyc(1'b1, 2'd3, 1'b0);
        checks++;
        if (u_if.idx !== 3'd1 || u_if.match !== 1'b1) begin
            errors++;
            $display("FAIL post_exit_accept got idx=%0d m=%b want idx=1 m=1", u_if.idx, u_if.match);
        end
        cyc(1'b0, 2'd0, 1'b1);
    endtask

    task automatic test_lockout;
        cyc(1'b1, 2'd0, 1'b0);
        checks++;
        if (u_if.fail_cnt !== 2'd1 || u_if.alarm !== 1'b0) begin
            errors++;
            $display("FAIL lock_f1 got fc=%0d a=%b want fc=1 a=0", u_if.fail_cnt, u_if.alarm);
        end
        cyc(1'b1, 2'd0, 1'b0);
        checks++;
        if (u_if.fail_cnt !== 2'd2 || u_if.alarm !== 1'b0) begin
            errors++;
            $display("FAIL lock_f2 got fc=%0d a=%b want fc=2 a=0", u_if.fail_cnt, u_if.alarm);
        end
        cyc(1'b1, 2'd0, 1'b0);
        checks++;
        if (u_if.fail_cnt !== 2'd0 || u_if.alarm !== 1'b1) begin
            errors++;
            $display("FAIL lock_enter got fc=%0d a=%b want fc=0 a=1", u_if.fail_cnt, u_if.alarm);
        end
        begin
            logic [1:0] syms [4];
            syms = '{2'd3, 2'd1, 2'd0, 2'd2};
            for (int i = 0; i < 4; i++) begin
                cyc(1'b1, syms[i], 1'b0);
                checks++;
                if (u_if.idx !== 3'd0 || u_if.unlocked !== 1'b0 || u_if.alarm !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_ignore step=%0d got idx=%0d u=%b a=%b want idx=0 u=0 a=1",
                             i, u_if.idx, u_if.unlocked, u_if.alarm);
                end
            end
        end
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 2'd0, i == 3);
            checks++;
            if (u_if.alarm !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold cyc=%0d got alarm=%b want 1", i + 6, u_if.alarm);
            end
        end
        cyc(1'b1, 2'd3, 1'b0);
        checks++;
        if (u_if.alarm !== 1'b0 || u_if.idx !== 3'd0) begin
            errors++;
            $display("FAIL lock_exit got a=%b idx=%0d want a=0 idx=0", u_if.alarm, u_if.idx);
        end
        cyc(1'b1, 2'd3, 1'b0);
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0);
        checks++;
        if (u_if.unlocked !== 1'b1) begin
            errors++;
            $display("FAIL lock_recover got unlocked=%b want 1", u_if.unlocked);
        end
        cyc(1'b0, 2'd0, 1'b1);
    endtask

    task automatic test_clear_mid;
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd3, 1'b0);
        cyc(1'b1, 2'd1, 1'b0);
        checks++;
        if (u_if.idx !== 3'd2 || u_if.fail_cnt !== 2'd1) begin
            errors++;
            $display("FAIL clear_pre got idx=%0d fc=%0d want idx=2 fc=1", u_if.idx, u_if.fail_cnt);
        end
        cyc(1'b1, 2'd0, 1'b1);
        checks++;
        if (u_if.idx !== 3'd0 || u_if.fail_cnt !== 2'd1 || u_if.match !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid got idx=%0d fc=%0d m=%b want idx=0 fc=1 m=0",
                     u_if.idx, u_if.fail_cnt, u_if.match);
        end
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 2'd3, 1'b0);
        cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd0, 1'b0);
        checks++;
        if (u_if.idx !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_pre got idx=%0d want 3", u_if.idx);
        end
        rst_n = 1'b0;
        cyc(1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        checks++;
        if ({u_if.unlocked, u_if.alarm, u_if.match, u_if.idx, u_if.fail_cnt} !== 8'd0) begin
            errors++;
            $display("FAIL rstmid got u=%b a=%b m=%b idx=%0d fc=%0d want all 0",
                     u_if.unlocked, u_if.alarm, u_if.match, u_if.idx, u_if.fail_cnt);
        end
        cyc(1'b1, 2'd2, 1'b0);
        checks++;
        if (u_if.fail_cnt !== 2'd1 || u_if.idx !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_after got fc=%0d idx=%0d want fc=1 idx=0", u_if.fail_cnt, u_if.idx);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        u_if.sym_valid = 1'b0;
        u_if.sym       = 2'd0;
        u_if.clear     = 1'b0;
        @(negedge clk);
        test_reset;
        test_open;
        test_wrong_then_right;
        test_lockout;
        test_clear_mid;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
